mm_result_drain: RTL

MM_RESULT_DRAIN -- requirements
Module: mm_result_drain

---
 rtl/mm_result_drain_if.sv | 42 ++++
 rtl/mm_result_drain.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mm_result_drain_if.sv
// ============================================================================
// mm_result_drain_if : control, MXU result and RAM write signals of the drain
// Rev 1.0
// ============================================================================
`default_nettype none

interface mm_result_drain_if;
  logic         lsu_mm_drain_ctrl_vld;
  logic [3:0]   lsu_mm_drain_ctrl_row_len;
  logic [3:0]   lsu_mm_drain_ctrl_col_len;
  logic [11:0]  lsu_mm_drain_ctrl_start_addr;
  logic [15:0]  lsu_mm_drain_mxu_vld;
  logic [127:0] lsu_mm_drain_mxu_data;
  logic         lsu_mm_drain_ram_wr_vld;
  logic         lsu_mm_drain_ram_wr_rdy;
  logic [7:0]   lsu_mm_drain_ram_wr_addr;
  logic [127:0] lsu_mm_drain_ram_wr_data;
  logic [15:0]  lsu_mm_drain_ram_wr_strb;
  logic         lsu_mm_drain_busy;
  logic         lsu_mm_drain_done;
  logic         lsu_mm_drain_err;

  // Drain block side
  modport master (
    input  lsu_mm_drain_ctrl_vld, lsu_mm_drain_ctrl_row_len, lsu_mm_drain_ctrl_col_len,
    input  lsu_mm_drain_ctrl_start_addr, lsu_mm_drain_mxu_vld, lsu_mm_drain_mxu_data,
    input  lsu_mm_drain_ram_wr_rdy,
    output lsu_mm_drain_ram_wr_vld, lsu_mm_drain_ram_wr_addr, lsu_mm_drain_ram_wr_data,
    output lsu_mm_drain_ram_wr_strb, lsu_mm_drain_busy, lsu_mm_drain_done, lsu_mm_drain_err
  );

  // Controller / MXU / RAM side
  modport slave (
    output lsu_mm_drain_ctrl_vld, lsu_mm_drain_ctrl_row_len, lsu_mm_drain_ctrl_col_len,
    output lsu_mm_drain_ctrl_start_addr, lsu_mm_drain_mxu_vld, lsu_mm_drain_mxu_data,
    output lsu_mm_drain_ram_wr_rdy,
    input  lsu_mm_drain_ram_wr_vld, lsu_mm_drain_ram_wr_addr, lsu_mm_drain_ram_wr_data,
    input  lsu_mm_drain_ram_wr_strb, lsu_mm_drain_busy, lsu_mm_drain_done, lsu_mm_drain_err
  );
endinterface

`default_nettype wire

// File: rtl/mm_result_drain.sv
// ============================================================================
// mm_result_drain : de-skews MXU bottom-edge lanes into rows and writes them
//                   to RAM in row order with a vld/rdy handshake.
// Rev 1.0
// ============================================================================
`default_nettype none

module mm_result_drain (
  input  logic              clk,
  input  logic              rst,
  mm_result_drain_if.master drain_if
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic         ctrl_vld_ff_q;
  logic [4:0]   lane_cnt_q [16];
  logic [4:0]   lane_cnt_d [16];
  logic [4:0]   wp_q, wp_d;
  logic         err_q, err_d;
  logic         wr_vld_q, wr_vld_d;
  logic [7:0]   wr_addr_q, wr_addr_d;
  logic [127:0] wr_data_q, wr_data_d;
  logic [15:0]  wr_strb_q, wr_strb_d;
  logic [127:0] buf_q [16];

  logic [15:0]  lane_wr;
  logic         row_ok;
  logic [7:0]   lane_byte;
  logic         start;
  logic [3:0]   row_len;
  logic [3:0]   col_len;
  logic [15:0]  strb_mask;
  logic         w_unused_addr_lsb;

  assign row_len           = drain_if.lsu_mm_drain_ctrl_row_len;
  assign col_len           = drain_if.lsu_mm_drain_ctrl_col_len;
  assign start             = drain_if.lsu_mm_drain_ctrl_vld & ~ctrl_vld_ff_q;
  assign strb_mask         = 16'hFFFF >> (4'd15 - col_len);
  assign w_unused_addr_lsb = ^drain_if.lsu_mm_drain_ctrl_start_addr[3:0];

  always_comb begin
    state_d    = state_q;
    lane_cnt_d = lane_cnt_q;
    wp_d       = wp_q;
    err_d      = err_q;
    wr_vld_d   = wr_vld_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_strb_d  = wr_strb_q;
    lane_wr    = '0;
    row_ok     = 1'b1;
    lane_byte  = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_COLLECT;
          for (int j = 0; j < 16; j++) lane_cnt_d[j] = '0;
          wp_d     = '0;
          err_d    = 1'b0;
          wr_vld_d = 1'b0;
        end
      end

      ST_COLLECT: begin
        if (!drain_if.lsu_mm_drain_ctrl_vld) begin
          state_d  = ST_IDLE;
          wr_vld_d = 1'b0;
        end else begin
          for (int j = 0; j < 16; j++) begin
            if (drain_if.lsu_mm_drain_mxu_vld[j] && (4'(j) <= col_len)) begin
              if (lane_cnt_q[j] <= {1'b0, row_len}) begin
                lane_wr[j]    = 1'b1;
                lane_cnt_d[j] = lane_cnt_q[j] + 5'd1;
              end else begin
                err_d = 1'b1;
              end
            end
          end

          if (wr_vld_q && drain_if.lsu_mm_drain_ram_wr_rdy) wp_d = wp_q + 5'd1;

          if (wr_vld_q && !drain_if.lsu_mm_drain_ram_wr_rdy) begin
            wr_vld_d = 1'b1;
          end else if (wp_d > {1'b0, row_len}) begin
            wr_vld_d = 1'b0;
            state_d  = ST_DONE;
          end else begin
            // Row wp_d is judged on next-cycle counters so a row completed
            // this cycle presents on the very next edge.
            for (int j = 0; j < 16; j++) begin
              if ((4'(j) <= col_len) && (lane_cnt_d[j] <= wp_d)) row_ok = 1'b0;
            end
            wr_vld_d  = row_ok;
            wr_addr_d = drain_if.lsu_mm_drain_ctrl_start_addr[11:4] + {3'b000, wp_d};
            wr_strb_d = strb_mask;
            for (int j = 0; j < 16; j++) begin
              if (lane_wr[j] && (lane_cnt_q[j][3:0] == wp_d[3:0]))
                lane_byte = drain_if.lsu_mm_drain_mxu_data[8*j +: 8];
              else
                lane_byte = buf_q[wp_d[3:0]][8*j +: 8];
              wr_data_d[8*j +: 8] = strb_mask[j] ? lane_byte : 8'h00;
            end
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ctrl_vld_ff_q <= 1'b0;
      for (int j = 0; j < 16; j++) lane_cnt_q[j] <= '0;
      wp_q          <= '0;
      err_q         <= 1'b0;
      wr_vld_q      <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_strb_q     <= '0;
    end else begin
      state_q       <= state_d;
      ctrl_vld_ff_q <= drain_if.lsu_mm_drain_ctrl_vld;
      lane_cnt_q    <= lane_cnt_d;
      wp_q          <= wp_d;
      err_q         <= err_d;
      wr_vld_q      <= wr_vld_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      wr_strb_q     <= wr_strb_d;
    end
  end

  // Row buffer holds only data; validity lives in the lane counters.
  always_ff @(posedge clk) begin
    for (int j = 0; j < 16; j++) begin
      if (lane_wr[j])
        buf_q[lane_cnt_q[j][3:0]][8*j +: 8] <= drain_if.lsu_mm_drain_mxu_data[8*j +: 8];
    end
  end

  assign drain_if.lsu_mm_drain_ram_wr_vld  = wr_vld_q;
  assign drain_if.lsu_mm_drain_ram_wr_addr = wr_addr_q;
  assign drain_if.lsu_mm_drain_ram_wr_data = wr_data_q;
  assign drain_if.lsu_mm_drain_ram_wr_strb = wr_strb_q;
  assign drain_if.lsu_mm_drain_busy        = (state_q != ST_IDLE);
  assign drain_if.lsu_mm_drain_done        = (state_q == ST_DONE);
  assign drain_if.lsu_mm_drain_err         = err_q;

endmodule

`default_nettype wire
